// File: rtl/sqrt_iter.sv
// Iterative integer square root, digit-by-digit restoring algorithm.
// Consumes two operand bits and produces one root bit per clock; a start/busy
// handshake with a one-cycle endop strobe, truncated remainder output and
// optional round-to-nearest of the root.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operand and round mode captured on accept
// CALC  | one root bit per cycle, RW cycles total
// FIN   | publish root/remainder, apply rounding, pulse endop
module sqrt_iter #(
  parameter int WIDTH         = 16,
  parameter bit ROUND_DEFAULT = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     valor,
  input  logic                 round_en,
  output logic                 busy,
  output logic                 endop,
  output logic [WIDTH/2-1:0]   sqrt,
  output logic [WIDTH/2:0]     rem
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] opnd_q;
  logic [RW+1:0]   prem_q;
  logic [RW-1:0]   proot_q;
  logic [CW-1:0]   cnt_q;
  logic            rnd_q;

  logic [RW+1:0]   shifted;
  logic [RW+1:0]   subtrahend;
  logic [RW+2:0]   trial;
  logic            round_up;

  // Trial subtraction for the current digit. Before each shift the partial
  // remainder never exceeds RW bits, so only its low RW bits are shifted in.
  always_comb begin
    shifted    = {prem_q[RW-1:0], opnd_q[WIDTH-1 -: 2]};
    subtrahend = {proot_q, 2'b01};
    trial      = {1'b0, shifted} - {1'b0, subtrahend};
    round_up   = rnd_q && (prem_q > {2'b00, proot_q}) && (proot_q != {RW{1'b1}});
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, per-digit iteration and result publication.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opnd_q  <= '0;
      prem_q  <= '0;
      proot_q <= '0;
      cnt_q   <= '0;
      rnd_q   <= ROUND_DEFAULT;
      endop   <= 1'b0;
      sqrt    <= '0;
      rem     <= '0;
    end else begin
      endop <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_q  <= valor;
            rnd_q   <= round_en;
            prem_q  <= '0;
            proot_q <= '0;
            cnt_q   <= CW'(RW - 1);
          end
        end
        CALC: begin
          opnd_q <= opnd_q << 2;
          cnt_q  <= cnt_q - 1'b1;
          if (!trial[RW+2]) begin
            prem_q  <= trial[RW+1:0];
            proot_q <= {proot_q[RW-2:0], 1'b1};
          end else begin
            prem_q  <= shifted;
            proot_q <= {proot_q[RW-2:0], 1'b0};
          end
        end
        FIN: begin
          rem   <= prem_q[RW:0];
          sqrt  <= round_up ? proot_q + 1'b1 : proot_q;
          endop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: WIDTH=16 instance for the directed cases and
// handshake behaviour, WIDTH=8 instance for an exhaustive sweep.
module tb_sqrt_iter;

  logic        clock = 1'b0;
  logic        reset;

  logic        s16, r16, busy16, end16;
  logic [15:0] v16;
  logic [7:0]  sq16;
  logic [8:0]  rm16;

  logic        s8, r8, busy8, end8;
  logic [7:0]  v8;
  logic [3:0]  sq8;
  logic [4:0]  rm8;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sqrt_iter #(.WIDTH(16), .ROUND_DEFAULT(1'b0)) dut16 (
    .clock(clock), .reset(reset), .start(s16), .valor(v16), .round_en(r16),
    .busy(busy16), .endop(end16), .sqrt(sq16), .rem(rm16)
  );

  sqrt_iter #(.WIDTH(8), .ROUND_DEFAULT(1'b0)) dut8 (
    .clock(clock), .reset(reset), .start(s8), .valor(v8), .round_en(r8),
    .busy(busy8), .endop(end8), .sqrt(sq8), .rem(rm8)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: floor root by search, remainder, optional saturating round.
  task automatic model(input int v, input bit rnd, input int maxr,
                       output int s, output int r);
    int q;
    q = 0;
    while ((q + 1) * (q + 1) <= v) q++;
    r = v - q * q;
    s = (rnd && r > q && q != maxr) ? q + 1 : q;
  endtask

  // One request; reports result and the number of edges from accept to endop.
  task automatic op(input bit w8, input int v, input bit rnd,
                    output int s, output int r, output int lat);
    @(negedge clock);
    if (w8) begin s8 = 1'b1; v8 = v[7:0]; r8 = rnd; end
    else    begin s16 = 1'b1; v16 = v[15:0]; r16 = rnd; end
    @(posedge clock); #1;
    s8 = 1'b0; s16 = 1'b0;
    lat = 0; s = -1; r = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      lat++;
      if (w8 ? end8 : end16) begin
        s = w8 ? int'(sq8) : int'(sq16);
        r = w8 ? int'(rm8) : int'(rm16);
        break;
      end
    end
  endtask

  task automatic run(input string tag, input bit w8, input int v, input bit rnd,
                     input int es, input int er, input int elat);
    int s, r, lat;
    op(w8, v, rnd, s, r, lat);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".sqrt"}, s, es);
    chk({tag, ".rem"}, r, er);
    @(posedge clock); #1;
    chk({tag, ".endop_1cyc"}, w8 ? int'(end8) : int'(end16), 0);
  endtask

  initial begin
    int s, r, lat, t0, t1, t2, cnt;
    int exp_s [3];
    int nxt_v [3];
    reset = 1'b0;
    s16 = 0; v16 = '0; r16 = 0;
    s8 = 0; v8 = '0; r8 = 0;
    #1;
    chk("rst.busy", busy16, 0);
    chk("rst.endop", end16, 0);
    chk("rst.sqrt", sq16, 0);
    chk("rst.rem", rm16, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run("v4",      0, 4,     0, 2,   0,   9);
    run("v16",     0, 16,    0, 4,   0,   9);
    run("v0",      0, 0,     0, 0,   0,   9);
    run("vmax",    0, 65535, 0, 255, 510, 9);
    run("vmax_rn", 0, 65535, 1, 255, 510, 9);
    run("v20_rn",  0, 20,    1, 4,   4,   9);
    run("v21_rn",  0, 21,    1, 5,   5,   9);
    run("v21",     0, 21,    0, 4,   5,   9);

    // Back-to-back with start held high; valor changes while busy are ignored.
    exp_s = '{2, 3, 4};
    nxt_v = '{9, 16, 0};
    t0 = 0; t1 = 0; t2 = 0;
    @(negedge clock);
    s16 = 1'b1; v16 = 16'd4; r16 = 1'b0;
    @(posedge clock); #1;
    v16 = 16'd99;
    for (int k = 0; k < 3; k++) begin
      s = -1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clock); #1;
        if (end16) begin s = sq16; break; end
      end
      if (k == 0) t0 = cyc; else if (k == 1) t1 = cyc; else t2 = cyc;
      chk($sformatf("b2b%0d.sqrt", k), s, exp_s[k]);
      if (k == 2) s16 = 1'b0;
      else        v16 = nxt_v[k][15:0];
      if (k < 2) begin @(posedge clock); #1; v16 = 16'd99; end
    end
    chk("b2b.gap01", t1 - t0, 10);
    chk("b2b.gap12", t2 - t1, 10);
    repeat (2) @(posedge clock);

    // Start pulse mid-CALC must not alter or requeue anything.
    @(negedge clock);
    s16 = 1'b1; v16 = 16'd25; r16 = 1'b0;
    @(posedge clock); #1;
    s16 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); s16 = 1'b1; v16 = 16'd100;
    @(negedge clock); s16 = 1'b0;
    s = -1; r = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (end16) begin s = sq16; r = rm16; break; end
    end
    chk("ign.sqrt", s, 5);
    chk("ign.rem", r, 0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      if (end16) cnt++;
    end
    chk("ign.no_extra", cnt, 0);

    // Reset during the 4th CALC cycle aborts without endop.
    @(negedge clock);
    s16 = 1'b1; v16 = 16'd49;
    @(posedge clock); #1;
    s16 = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst.busy", busy16, 0);
    chk("arst.endop", end16, 0);
    chk("arst.sqrt", sq16, 0);
    chk("arst.rem", rm16, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (end16) cnt++;
    end
    chk("arst.no_endop", cnt, 0);
    run("v144", 0, 144, 0, 12, 0, 9);

    // Exhaustive WIDTH=8 sweep against the reference model.
    for (int v = 0; v < 256; v++) begin
      for (int rb = 0; rb < 2; rb++) begin
        int es, er;
        model(v, rb[0], 15, es, er);
        run($sformatf("w8_%0d_%0d", v, rb), 1, v, rb[0], es, er, 5);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
- Parametrised successor to the fixed 16-bit integer square-root unit.
- Computes floor(sqrt(valor)) for an unsigned operand of configurable width using a digit-by-digit restoring algorithm: two operand bits are consumed and one root bit is produced per clock.
- Adds a start/busy handshake, a remainder output, optional round-to-nearest, and safe back-to-back operation.
- Sits as a datapath leaf driven by a command/driver layer; endop is the completion strobe.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4. Root width RW = WIDTH/2.
- ROUND_DEFAULT, 0, value the latched rounding mode takes at reset.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; all state clears immediately while low.
- start  input  1  request; sampled only while busy=0.
- valor  input  WIDTH  unsigned operand; captured on the edge that accepts start.
- round_en  input  1  1 = round to nearest; captured together with valor.
- busy  output  1  high from the edge after acceptance until the FIN state completes.
- endop  output  1  one-cycle pulse; sqrt and rem are valid while it is high.
- sqrt  output  RW  result root; holds its value until the next endop.
- rem  output  RW+1  truncated remainder valor - floor(sqrt(valor))^2, range 0..2*floor_root.

Behaviour:
- Reset (reset=0): state=IDLE; busy=0, endop=0, sqrt=0, rem=0; internal registers cleared; latched round mode = ROUND_DEFAULT.
- A reset mid-operation aborts the operation. No endop is produced for the aborted request.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - On an edge with start=1, capture valor and round_en.
  - Clear the partial remainder and the partial root.
  - Load the iteration counter with RW-1 and go to CALC.
- CALC, each cycle:
  - trial = (partial_rem << 2 | next two operand bits, MSB pair first) - (partial_root << 2 | 1).
  - If trial >= 0: partial_rem = trial and partial_root = partial_root<<1 | 1.
  - Otherwise: partial_rem is shifted with the new bits but not subtracted, and partial_root = partial_root<<1.
  - Exactly RW cycles in CALC; go to FIN when the counter reaches 0.
- FIN:
  - rem <= partial_rem.
  - If round_en was latched, partial_rem > partial_root, and partial_root != all-ones: sqrt <= partial_root + 1.
  - Otherwise: sqrt <= partial_root. This means saturation at 2^RW-1; the output never wraps.
  - endop <= 1, then go to IDLE.
- endop is a registered output. It is high during the first IDLE cycle after FIN and is deasserted on the next edge.
- busy = (state != IDLE).
- Latency: start is accepted at edge N; endop is high in the cycle after edge N+RW+1. For WIDTH=16, that is 9 cycles.
- Back-to-back: start is accepted in the same cycle endop is high. A new request therefore costs RW+2 cycles with no bubble.
- start while busy=1 is ignored, not queued. valor and round_en changes while busy have no effect.
- rem always reports the truncated remainder, independent of rounding.
- Internal partial_rem width is RW+2 bits, which is sufficient to hold any intermediate trial.
- valor=0 yields sqrt=0, rem=0.

Test Plan:
- WIDTH=16, round_en=0:
  - valor=4 -> endop 9 cycles after acceptance, sqrt=2, rem=0.
  - valor=16 -> sqrt=4, rem=0.
- Boundaries:
  - valor=0 -> sqrt=0, rem=0.
  - valor=65535, round_en=0 -> sqrt=255, rem=510.
  - valor=65535, round_en=1 -> sqrt=255 (saturated), rem=510.
- Rounding:
  - valor=20, round_en=1 -> sqrt=4, rem=4.
  - valor=21, round_en=1 -> sqrt=5, rem=5.
  - valor=21, round_en=0 -> sqrt=4, rem=5.
- Handshake:
  - start=1 held continuously with valor stepping 4, 9, 16 on each acceptance -> three endop pulses spaced 10 cycles apart with sqrt=2, 3, 4.
  - A start pulse mid-CALC is ignored; the first result is unchanged.
- Reset mid-operation: reset=0 during the 4th CALC cycle -> outputs go to 0 immediately, no endop. After reset is released, valor=144 -> sqrt=12, rem=0.
- Exhaustive sweep: WIDTH=8, all valor 0..255 with both round_en values -> results match the reference model, endop exactly once per request.
